// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: writer end of the configuration-chain protocol.
// Accepts bitstream words on a valid/ready interface and shifts them LSB first
// into a tile's ccff_head with a shift enable, until CHAIN_LEN bits are in.
// Optional readback packer of ccff_tail is enabled with `define CCFF_READBACK_EN.
module ccff_bitstream_loader #(
    parameter int unsigned WORD_W    = 4,
    parameter int unsigned CHAIN_LEN = 10
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] word_in,
    input  logic              word_valid,
    output logic              word_ready,
    output logic              ccff_head,
    output logic              ccff_shift_en,
    input  logic              ccff_tail,
`ifdef CCFF_READBACK_EN
    output logic [WORD_W-1:0] rb_word,
    output logic              rb_valid,
`endif
    output logic              busy,
    output logic              done
);

    localparam int unsigned   CW     = $clog2(CHAIN_LEN + 1);
    localparam int unsigned   WW     = $clog2(WORD_W + 1);
    localparam logic [CW-1:0] LEN_C  = CW'(CHAIN_LEN);
    localparam logic [WW-1:0] WORD_C = WW'(WORD_W);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_SHIFT,
        ST_DONE
    } state_t;

    state_t            state_q;
    logic [WORD_W-1:0] sr_q;
    logic [CW-1:0]     bit_cnt_q;
    logic [WW-1:0]     word_left_q;
    logic              head_q;
    logic              shift_en_q;
    logic              busy_q;
    logic              done_q;

    logic [CW-1:0]     remain_d;
    logic [WW-1:0]     word_len_d;
    logic [WORD_W-1:0] sr_d;
    logic              word_end;
    logic              last_bit;

    // Derived counter values: length of the next word and end-of-word / end-of-load flags
    always_comb begin
        remain_d   = LEN_C - bit_cnt_q;
        word_len_d = WORD_C;
        if (32'(remain_d) < WORD_W) begin
            word_len_d = WW'(remain_d);
        end
        sr_d     = sr_q >> 1;
        word_end = (word_left_q == WW'(1));
        last_bit = word_end && ((bit_cnt_q + CW'(1)) == LEN_C);
    end

    assign word_ready    = (state_q == ST_LOAD) && !abort;
    assign ccff_head     = head_q;
    assign ccff_shift_en = shift_en_q;
    assign busy          = busy_q;
    assign done          = done_q;

    // Load FSM; head/shift_en/busy/done are registered alongside the state
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            sr_q        <= '0;
            bit_cnt_q   <= '0;
            word_left_q <= '0;
            head_q      <= 1'b0;
            shift_en_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state_q   <= ST_LOAD;
                        bit_cnt_q <= '0;
                        busy_q    <= 1'b1;
                        done_q    <= 1'b0;
                    end
                end
                ST_LOAD: begin
                    if (abort) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else if (word_valid) begin
                        state_q     <= ST_SHIFT;
                        sr_q        <= word_in;
                        word_left_q <= word_len_d;
                        head_q      <= word_in[0];
                        shift_en_q  <= 1'b1;
                    end
                end
                ST_SHIFT: begin
                    if (abort) begin
                        state_q    <= ST_IDLE;
                        busy_q     <= 1'b0;
                        head_q     <= 1'b0;
                        shift_en_q <= 1'b0;
                    end else begin
                        sr_q        <= sr_d;
                        bit_cnt_q   <= bit_cnt_q + CW'(1);
                        word_left_q <= word_left_q - WW'(1);
                        if (word_end) begin
                            head_q     <= 1'b0;
                            shift_en_q <= 1'b0;
                            if (last_bit) begin
                                state_q <= ST_DONE;
                                busy_q  <= 1'b0;
                                done_q  <= 1'b1;
                            end else begin
                                state_q <= ST_LOAD;
                            end
                        end else begin
                            head_q <= sr_d[0];
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_sr_q;
    logic [WORD_W-1:0] rb_word_q;
    logic [WORD_W-1:0] rb_pack;
    logic [WW-1:0]     rb_cnt_q;
    logic [WW-1:0]     rb_fill;
    logic              rb_valid_q;
    logic              rb_clear;

    // Tail bits enter at the MSB; a partial word is right-aligned when flushed
    always_comb begin
        rb_pack             = rb_sr_q >> 1;
        rb_pack[WORD_W-1]   = ccff_tail;
        rb_fill             = rb_cnt_q + WW'(1);
        rb_clear            = (((state_q == ST_LOAD) || (state_q == ST_SHIFT)) && abort) ||
                              (((state_q == ST_IDLE) || (state_q == ST_DONE)) && start);
    end

    // Readback packer: emits one word per WORD_W shifted bits and at end of load
    always_ff @(posedge clk) begin
        if (reset) begin
            rb_sr_q    <= '0;
            rb_cnt_q   <= '0;
            rb_word_q  <= '0;
            rb_valid_q <= 1'b0;
        end else begin
            rb_valid_q <= 1'b0;
            if (rb_clear) begin
                rb_sr_q  <= '0;
                rb_cnt_q <= '0;
            end else if (shift_en_q) begin
                if ((rb_fill == WORD_C) || last_bit) begin
                    rb_word_q  <= rb_pack >> (WORD_C - rb_fill);
                    rb_valid_q <= 1'b1;
                    rb_sr_q    <= '0;
                    rb_cnt_q   <= '0;
                end else begin
                    rb_sr_q  <= rb_pack;
                    rb_cnt_q <= rb_fill;
                end
            end
        end
    end

    assign rb_word  = rb_word_q;
    assign rb_valid = rb_valid_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
`endif

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
// Bench for ccff_bitstream_loader (WORD_W=4, CHAIN_LEN=10).
// Expected bit streams are built from the word list; a simple chain model
// drives ccff_tail so readback can be checked when CCFF_READBACK_EN is set.
module tb_ccff_bitstream_loader;

    localparam int WORD_W    = 4;
    localparam int CHAIN_LEN = 10;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              abort;
    logic [WORD_W-1:0] word_in;
    logic              word_valid;
    logic              word_ready;
    logic              ccff_head;
    logic              ccff_shift_en;
    logic              ccff_tail;
    logic              busy;
    logic              done;
`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_word;
    logic              rb_valid;
`endif

    ccff_bitstream_loader #(
        .WORD_W   (WORD_W),
        .CHAIN_LEN(CHAIN_LEN)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .word_in      (word_in),
        .word_valid   (word_valid),
        .word_ready   (word_ready),
        .ccff_head    (ccff_head),
        .ccff_shift_en(ccff_shift_en),
        .ccff_tail    (ccff_tail),
`ifdef CCFF_READBACK_EN
        .rb_word      (rb_word),
        .rb_valid     (rb_valid),
`endif
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;

    bit               got_bits[$];
    bit               exp_bits[$];
    logic [WORD_W-1:0] load_words[$];

    // Model of the configuration chain behind the loader
    logic [CHAIN_LEN-1:0] chain;
    logic                 preload;
    assign ccff_tail = chain[0];
    always @(posedge clk) begin
        if (preload) chain <= 10'h2B5;
        else if (ccff_shift_en) chain <= {ccff_head, chain[CHAIN_LEN-1:1]};
    end

    always @(negedge clk) begin
        if (ccff_shift_en) got_bits.push_back(ccff_head);
    end

`ifdef CCFF_READBACK_EN
    logic [WORD_W-1:0] rb_got[$];
    always @(negedge clk) begin
        if (rb_valid) rb_got.push_back(rb_word);
    end
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Stream of bits the chain should receive: words LSB first, cut at CHAIN_LEN
    task automatic build_expected();
        exp_bits.delete();
        foreach (load_words[k]) begin
            for (int b = 0; b < WORD_W; b++) begin
                if (exp_bits.size() < CHAIN_LEN) exp_bits.push_back(load_words[k][b]);
            end
        end
    endtask

    task automatic pulse_start();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Wait for LOAD, hold off for 'stall' cycles, then hand over one word
    task automatic drive_word(input logic [WORD_W-1:0] w, input int stall);
        bit seen = 1'b0;
        word_valid = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (word_ready) begin
                seen = 1'b1;
                break;
            end
        end
        check("ready_wait", 32'(seen), 32'd1);
        check("shen_in_load", 32'(ccff_shift_en), 32'd0);
        check("busy_in_load", 32'(busy), 32'd1);
        for (int i = 0; i < stall; i++) begin
            check("stall_ready", 32'(word_ready), 32'd1);
            check("stall_shen", 32'(ccff_shift_en), 32'd0);
            @(negedge clk);
        end
        word_in    = w;
        word_valid = 1'b1;
        @(posedge clk); #1;
        word_valid = 1'b0;
        word_in    = WORD_W'($urandom);
        @(negedge clk);
        check("first_bit_shen", 32'(ccff_shift_en), 32'd1);
        check("first_bit_head", 32'(ccff_head), 32'(w[0]));
        check("ready_in_shift", 32'(word_ready), 32'd0);
    endtask

    // Full load of load_words; stall_second>=0 forces the stall before word 1
    task automatic do_load(input int stall_max, input int stall_second, input bit poke_start);
        int last_sh = -1;
        int dn      = -1;
        int st;
        build_expected();
        got_bits.delete();
        pulse_start();
        foreach (load_words[k]) begin
            st = int'($urandom_range(0, stall_max));
            if (k == 1 && stall_second >= 0) st = stall_second;
            if (k == 1 && poke_start) pulse_start();
            drive_word(load_words[k], st);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (ccff_shift_en) last_sh = i;
            if (done) begin
                dn = i;
                break;
            end
        end
        check("done_seen", 32'(dn >= 0), 32'd1);
        check("done_latency", 32'(dn - last_sh), 32'd1);
        check("busy_at_done", 32'(busy), 32'd0);
        check("nbits", 32'(got_bits.size()), 32'(CHAIN_LEN));
        for (int i = 0; i < CHAIN_LEN; i++) begin
            check($sformatf("bit%0d", i), 32'(got_bits[i]), 32'(exp_bits[i]));
        end
        repeat (2) @(negedge clk);
        check("done_held", 32'(done), 32'd1);
        check("shen_at_done", 32'(ccff_shift_en), 32'd0);
    endtask

    task automatic set_random_words();
        load_words.delete();
        for (int k = 0; k < (CHAIN_LEN + WORD_W - 1) / WORD_W; k++) begin
            load_words.push_back(WORD_W'($urandom));
        end
    endtask

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        word_in    = '0;
        word_valid = 1'b0;
        preload    = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        preload = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(word_ready), 32'd0);
        check("rst_head", 32'(ccff_head), 32'd0);
        check("rst_shen", 32'(ccff_shift_en), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0;

        // Basic load and backpressure before the second word
        load_words = '{4'hA, 4'h5, 4'h3};
        do_load(0, -1, 1'b0);
        do_load(0, 5, 1'b0);

        // Abort after six shifted bits
        set_random_words();
        build_expected();
        got_bits.delete();
        pulse_start();
        drive_word(load_words[0], 0);
        drive_word(load_words[1], 0);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_shen", 32'(ccff_shift_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_ready", 32'(word_ready), 32'd0);
        check("abort_nbits", 32'(got_bits.size()), 32'd6);
        set_random_words();
        do_load(2, -1, 1'b0);

        // Reset while shifting
        set_random_words();
        pulse_start();
        drive_word(load_words[0], 0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check("midrst_ready", 32'(word_ready), 32'd0);
        check("midrst_head", 32'(ccff_head), 32'd0);
        check("midrst_shen", 32'(ccff_shift_en), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_done", 32'(done), 32'd0);

        // Random loads, some with start pulsed while busy
        for (int n = 0; n < 6; n++) begin
            set_random_words();
            do_load(3, -1, n[0]);
        end

`ifdef CCFF_READBACK_EN
        begin
            logic [CHAIN_LEN-1:0] init = 10'h2B5;
            int nexp = 0;
            @(posedge clk); #1;
            preload = 1'b1;
            @(posedge clk); #1;
            preload = 1'b0;
            rb_got.delete();
            set_random_words();
            do_load(1, -1, 1'b0);
            for (int k = 0; k * WORD_W < CHAIN_LEN; k++) begin
                int n = (CHAIN_LEN - k * WORD_W < WORD_W) ? CHAIN_LEN - k * WORD_W : WORD_W;
                logic [31:0] expv = (32'(init) >> (k * WORD_W)) & ((32'd1 << n) - 32'd1);
                check($sformatf("rb_word%0d", k), 32'(rb_got[k]), expv);
                nexp++;
            end
            check("rb_count", 32'(rb_got.size()), 32'(nexp));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
